noise_channel: RTL and testbench
================================

Name: noise_channel

Overview:
- Parametrised serial bit-error injector for the Hamming-code link. Sits between encoder serialiser and decoder deserialiser.
- Tracks bit position within a frame of FRAME_LEN bits and flips selected bits. Selection uses one of three modes: fixed positions (up to NUM_ERR), a contiguous burst, or LFSR-driven random errors.
- Counts injected errors so the bench can check decoder correction/detection claims.

Parameters:
FRAME_LEN, 16, bits per frame (2..2^IDX_W)
IDX_W, 4, width of bit index and address fields
NUM_ERR, 2, number of fixed error-position slots
CNT_W, 8, width of err_count
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
enable  in  1  global injection enable; 0 = pure pass-through (counting continues)
valid  in  1  datain carries a bit this cycle
frame_start  in  1  current valid bit is bit 0 of a frame
datain  in  1  serial data in
mode  in  2  00 pass, 01 fixed, 10 burst, 11 random
err_addr  in  NUM_ERR*IDX_W  packed fixed positions; slot 0 = bits [IDX_W-1:0]; slot 0 is also the burst start
burst_len  in  IDX_W  burst length in bits
threshold  in  16  random mode: flip when lfsr < threshold
clr_count  in  1  synchronous clear of err_count
dataout  out  1  datain XOR flip (combinational, zero latency)
flip  out  1  current bit is being inverted
err_count  out  CNT_W  saturating count of flipped bits
frame_done  out  1  registered one-cycle pulse after last bit of a frame

Behaviour:
- States:
  - IDLE: reset state; no counting, flip=0.
  - ACTIVE: entered on valid&frame_start.
  - Returns to IDLE only via rst; frames run back-to-back after the first.
- cur_idx = frame_start ? 0 : idx.
- On each valid cycle with (ACTIVE or frame_start):
  - idx <= cur_idx+1, wrapping to 0 after FRAME_LEN-1.
  - frame_done <= (cur_idx==FRAME_LEN-1).
- frame_start mid-frame resyncs: that bit is index 0; no frame_done for the truncated frame.
- valid=0: idx, lfsr, err_count hold; flip=0; dataout=datain.
- flip = enable & valid & (ACTIVE | frame_start) & hit. hit by mode:
  - 00: 0.
  - 01: any slot k with err_addr[k]==cur_idx. Slots >= FRAME_LEN never hit. Duplicate slots flip once.
  - 10: err_addr[0] <= cur_idx < err_addr[0]+burst_len. Computed in IDX_W+1 bits, no wrap; a burst is truncated at frame end. burst_len=0 gives no flips.
  - 11: lfsr < threshold (unsigned). threshold=0 never flips.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (right shift, toggle mask 16'hB400).
  - Advances once per counted valid bit, independent of enable and mode.
  - Compare uses the pre-advance value.
- err_count:
  - +1 on each cycle with flip=1; saturates at all-ones.
  - clr_count has priority over a same-cycle increment (result 0).
- mode, err_addr, burst_len, threshold are sampled every bit; changes take effect on the next bit with no pipeline.
- Reset values (asynchronous): state IDLE, idx 0, lfsr LFSR_SEED, err_count 0, frame_done 0, flip 0, dataout=datain.
- Reset mid-frame abandons the frame; the next bit counts only after a new frame_start.

Optional Feature:
- NOISE_LFSR_EN defined: random mode (11) as described; LFSR register present.
- Not defined: no LFSR logic; mode 11 behaves as mode 00; threshold ignored.

Test Plan:
- Mode 01, err_addr slots {3,9}, enable=1, one 16-bit frame of all 0s → dataout 1 only at bits 3 and 9; err_count=2; frame_done pulse in the cycle after bit 15.
- Mode 01, slots {5,5} then {15,7} with FRAME_LEN=12 → single flip at 5; then single flip at 7 (15 ignored); err_count ends at 2.
- Mode 10, err_addr[0]=13, burst_len=6, 16-bit frame → flips at bits 13,14,15 only; burst_len=0 over the next frame → no flips.
- frame_start reasserted at bit 6 of frame with mode 01, slot 2 → flips at bit 2 of both the partial and the resynced frame; no frame_done for the partial frame; valid gaps do not advance the index.
- Mode 11 (NOISE_LFSR_EN defined), threshold=0 over 64 bits → zero flips.
- Mode 11, threshold=16'h8000, 64 bits → flip pattern and err_count match a golden Galois model seeded 16'hACE1.
- CNT_W=2, 5 flips → err_count saturates at 3; clr_count together with a flip → 0.
- rst asserted at bit 7 → outputs reset immediately; bits after rst release are not flipped until a new frame_start.

Source files
------------

// File: rtl/noise_channel.sv
// noise_channel: serial bit-error injector for the Hamming-code link.
// Tracks the bit position inside a frame of FRAME_LEN bits and inverts selected
// bits using fixed positions, a contiguous burst or LFSR-driven random errors.
// Optional feature: define NOISE_LFSR_EN to build the LFSR and enable random
// mode (11); without it mode 11 behaves as pass-through and threshold is ignored.
module noise_channel #(
  parameter int          FRAME_LEN = 16,
  parameter int          IDX_W     = 4,
  parameter int          NUM_ERR   = 2,
  parameter int          CNT_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     valid,
  input  logic                     frame_start,
  input  logic                     datain,
  input  logic [1:0]               mode,
  input  logic [NUM_ERR*IDX_W-1:0] err_addr,
  input  logic [IDX_W-1:0]         burst_len,
  input  logic [15:0]              threshold,
  input  logic                     clr_count,
  output logic                     dataout,
  output logic                     flip,
  output logic [CNT_W-1:0]         err_count,
  output logic                     frame_done
);

  // Frame length widened by one bit so slot/burst compares never wrap.
  localparam logic [IDX_W:0]   FRAME_LEN_X = (IDX_W+1)'(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   cur_idx_s;
  logic [IDX_W-1:0]   idx_nxt_s;
  logic               counted_s;
  logic               fixed_hit_s;
  logic               burst_hit_s;
  logic               rand_hit_s;
  logic               hit_s;
  logic               flip_s;
  logic [IDX_W:0]     cur_x_s;
  logic [IDX_W:0]     burst_start_s;
  logic [IDX_W:0]     burst_end_s;
  logic [CNT_W-1:0]   count_r;
  logic               frame_done_r;

  // Index of the current bit: frame_start forces index 0 (also resyncs mid-frame).
  assign cur_idx_s = frame_start ? {IDX_W{1'b0}} : idx_r;
  assign cur_x_s   = {1'b0, cur_idx_s};

  // A bit is counted once the first frame has started, or on the frame_start bit itself.
  assign counted_s = valid & ((state_r == ST_ACTIVE) | frame_start);

  // Next-state logic: leave IDLE on the first frame_start; only reset returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (valid && frame_start) begin
          state_nxt_s = ST_ACTIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: state_nxt_s = ST_ACTIVE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Fixed-position hit: any slot equal to the current index; out-of-frame slots never hit.
  always_comb begin
    fixed_hit_s = 1'b0;
    for (int k = 0; k < NUM_ERR; k++) begin
      if ((err_addr[k*IDX_W +: IDX_W] == cur_idx_s) &&
          ({1'b0, err_addr[k*IDX_W +: IDX_W]} < FRAME_LEN_X)) begin
        fixed_hit_s = 1'b1;
      end else begin
        fixed_hit_s = fixed_hit_s;
      end
    end
  end

  // Burst window [start, start+len) in IDX_W+1 bits so it is truncated at frame end.
  assign burst_start_s = {1'b0, err_addr[IDX_W-1:0]};
  assign burst_end_s   = burst_start_s + {1'b0, burst_len};
  assign burst_hit_s   = (cur_x_s >= burst_start_s) && (cur_x_s < burst_end_s);

`ifdef NOISE_LFSR_EN
  logic [15:0] lfsr_r;
  logic [15:0] lfsr_nxt_s;

  // Right-shift Galois step for x^16+x^14+x^13+x^11+1; compare uses the pre-advance value.
  assign lfsr_nxt_s = (lfsr_r >> 1) ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
  assign rand_hit_s = (lfsr_r < threshold);

  // LFSR advances once per counted bit regardless of enable and mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else if (counted_s) begin
      lfsr_r <= lfsr_nxt_s;
    end else begin
      lfsr_r <= lfsr_r;
    end
  end
`else
  logic unused_threshold_s;
  assign unused_threshold_s = ^{threshold, LFSR_SEED};
  assign rand_hit_s         = 1'b0;
`endif

  // Mode select for the hit decision.
  always_comb begin
    hit_s = 1'b0;
    case (mode)
      2'b00:   hit_s = 1'b0;
      2'b01:   hit_s = fixed_hit_s;
      2'b10:   hit_s = burst_hit_s;
      2'b11:   hit_s = rand_hit_s;
      default: hit_s = 1'b0;
    endcase
  end

  // Flip is suppressed during reset so the outputs read as reset immediately.
  assign flip_s  = ~rst & enable & counted_s & hit_s;
  assign flip    = flip_s;
  assign dataout = datain ^ flip_s;

  // Index increment with wrap after the last bit of the frame.
  assign idx_nxt_s = (cur_idx_s == LAST_IDX) ? {IDX_W{1'b0}} : (cur_idx_s + {{(IDX_W-1){1'b0}}, 1'b1});

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bit index and end-of-frame pulse; both hold across valid gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r        <= {IDX_W{1'b0}};
      frame_done_r <= 1'b0;
    end else if (counted_s) begin
      idx_r        <= idx_nxt_s;
      frame_done_r <= (cur_idx_s == LAST_IDX);
    end else begin
      idx_r        <= idx_r;
      frame_done_r <= 1'b0;
    end
  end

  // Saturating error counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr_count) begin
      count_r <= {CNT_W{1'b0}};
    end else if (flip_s && (count_r != CNT_MAX)) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign err_count  = count_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_noise_channel.sv
// Self-checking bench for noise_channel: two instances (16-bit frames / 8-bit
// counter and 12-bit frames / 2-bit counter) share one stimulus stream and are
// compared every cycle against a behavioural model, plus literal expectations.
module tb_noise_channel;

  logic       clk = 1'b0;
  logic       rst, enable, valid, frame_start, datain, clr_count;
  logic [1:0] mode;
  logic [7:0] err_addr;
  logic [3:0] burst_len;
  logic [15:0] threshold;

  logic       dout0, dout1, flip0, flip1, fd0, fd1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  int checks = 0;
  int errors = 0;

  // model state per instance
  int FL[2]   = '{16, 12};
  int CMAX[2] = '{255, 3};
  int m_idx[2];
  int m_lfsr[2];
  int m_cnt[2];
  bit m_act[2];
  bit m_fd[2];

  logic last0;
  logic [15:0] pat;

  always #5 clk = ~clk;

  noise_channel #(.FRAME_LEN(16), .IDX_W(4), .NUM_ERR(2), .CNT_W(8), .LFSR_SEED(16'hACE1)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .valid(valid), .frame_start(frame_start),
    .datain(datain), .mode(mode), .err_addr(err_addr), .burst_len(burst_len),
    .threshold(threshold), .clr_count(clr_count), .dataout(dout0), .flip(flip0),
    .err_count(cnt0), .frame_done(fd0));

  noise_channel #(.FRAME_LEN(12), .IDX_W(4), .NUM_ERR(2), .CNT_W(2), .LFSR_SEED(16'hACE1)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .valid(valid), .frame_start(frame_start),
    .datain(datain), .mode(mode), .err_addr(err_addr), .burst_len(burst_len),
    .threshold(threshold), .clr_count(clr_count), .dataout(dout1), .flip(flip1),
    .err_count(cnt1), .frame_done(fd1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lfsr_next(input int l);
    return ((l & 32'd1) != 0) ? ((l >> 1) ^ 32'hB400) : (l >> 1);
  endfunction

  // Error selection straight from the mode rules.
  function automatic bit model_hit(input int i, input int cur, input int lfsr);
    int s;
    case (mode)
      2'b01: begin
        for (int k = 0; k < 2; k++) begin
          s = (err_addr >> (4 * k)) & 32'd15;
          if (s < FL[i] && s == cur) return 1'b1;
        end
        return 1'b0;
      end
      2'b10: begin
        s = err_addr & 32'd15;
        return (cur >= s) && (cur < s + burst_len);
      end
`ifdef NOISE_LFSR_EN
      2'b11: return lfsr < threshold;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Per-cycle comparison of all outputs, then model advance for the coming edge.
  int  cur_m;
  bit  cnt_m, ef_m;
  logic        a_flip, a_dout, a_fd;
  logic [31:0] a_cnt;
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_idx[i] = 0; m_act[i] = 1'b0; m_lfsr[i] = 32'hACE1; m_cnt[i] = 0; m_fd[i] = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      cur_m = frame_start ? 0 : m_idx[i];
      cnt_m = !rst && valid && (m_act[i] || frame_start);
      ef_m  = enable && cnt_m && model_hit(i, cur_m, m_lfsr[i]);
      a_flip = (i == 0) ? flip0 : flip1;
      a_dout = (i == 0) ? dout0 : dout1;
      a_fd   = (i == 0) ? fd0 : fd1;
      a_cnt  = (i == 0) ? {24'd0, cnt0} : {30'd0, cnt1};
      chk($sformatf("flip%0d", i), {31'd0, a_flip}, {31'd0, ef_m});
      chk($sformatf("dataout%0d", i), {31'd0, a_dout}, {31'd0, datain ^ ef_m});
      chk($sformatf("err_count%0d", i), a_cnt, m_cnt[i]);
      chk($sformatf("frame_done%0d", i), {31'd0, a_fd}, {31'd0, m_fd[i]});
      if (!rst) begin
        m_fd[i] = cnt_m && (cur_m == FL[i] - 1);
        if (cnt_m) begin
          m_idx[i]  = (cur_m + 1) % FL[i];
          m_lfsr[i] = lfsr_next(m_lfsr[i]);
        end
        if (clr_count) m_cnt[i] = 0;
        else if (ef_m && m_cnt[i] < CMAX[i]) m_cnt[i] = m_cnt[i] + 1;
        if (valid && frame_start) m_act[i] = 1'b1;
      end
    end
  end

  // Caller sits at posedge+1; drive one cycle, sample dout0 mid-cycle, return at next posedge+1.
  task automatic step(input logic v, input logic fs, input logic d, input logic clr);
    valid = v; frame_start = fs; datain = d; clr_count = clr;
    @(negedge clk);
    last0 = dout0;
    @(posedge clk);
    #1;
  endtask

  task automatic frame16(input string name, input logic [15:0] exp);
    for (int b = 0; b < 16; b++) begin
      step(1'b1, b == 0, 1'b0, 1'b0);
      pat[b] = last0;
    end
    chk(name, {16'd0, pat}, {16'd0, exp});
  endtask

  initial begin
    int l;
    rst = 1'b1; enable = 1'b0; valid = 1'b0; frame_start = 1'b0; datain = 1'b0;
    clr_count = 1'b0; mode = 2'b00; err_addr = 8'd0; burst_len = 4'd0; threshold = 16'd0;

    // pin the model LFSR against hand-computed steps
    chk("lfsr_pin1", lfsr_next(32'hACE1), 32'hE270);
    l = 32'hACE1;
    for (int i = 0; i < 6; i++) l = lfsr_next(l);
    chk("lfsr_pin6", l, 32'hB313);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_cnt", {24'd0, cnt0}, 32'd0);
    chk("reset_fd", {31'd0, fd0}, 32'd0);
    chk("reset_flip", {31'd0, flip0}, 32'd0);
    rst = 1'b0;

    // fixed slots {3,9}
    enable = 1'b1; mode = 2'b01; err_addr = {4'd9, 4'd3};
    frame16("fixed_pattern", 16'h0208);
    chk("fixed_count", {24'd0, cnt0}, 32'd2);
    chk("fixed_done", {31'd0, fd0}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // duplicate slots then an out-of-frame slot on the 12-bit instance
    err_addr = {4'd5, 4'd5};
    for (int b = 0; b < 12; b++) step(1'b1, b == 0, 1'b0, 1'b0);
    err_addr = {4'd15, 4'd7};
    for (int b = 0; b < 12; b++) step(1'b1, b == 0, 1'b0, 1'b0);
    chk("dup_count12", {30'd0, cnt1}, 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // burst 13..15 truncated at frame end, then zero-length burst
    mode = 2'b10; err_addr = {4'd0, 4'd13}; burst_len = 4'd6;
    frame16("burst_pattern", 16'hE000);
    burst_len = 4'd0;
    frame16("burst_zero", 16'h0000);
    chk("burst_count", {24'd0, cnt0}, 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // resync: partial frame with a gap, frame_start again at bit 6
    mode = 2'b01; err_addr = {4'd2, 4'd2};
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("resync_bit2", {31'd0, last0}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    frame16("resync_pattern", 16'h0004);
    chk("resync_count", {24'd0, cnt0}, 32'd2);
    chk("resync_done", {31'd0, fd0}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // random mode: threshold 0 never flips, then half threshold vs model
    mode = 2'b11; threshold = 16'd0;
    for (int b = 0; b < 64; b++) step(1'b1, b == 0, b[0], 1'b0);
    chk("rand_zero", {24'd0, cnt0}, 32'd0);
    threshold = 16'h8000;
    for (int b = 0; b < 64; b++) step(1'b1, b == 0, b[1], 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // saturation on the 2-bit counter, then clear together with a flip
    mode = 2'b10; err_addr = 8'd0; burst_len = 4'd15;
    for (int b = 0; b < 6; b++) step(1'b1, b == 0, 1'b0, 1'b0);
    chk("sat_count2", {30'd0, cnt1}, 32'd3);
    chk("sat_count8", {24'd0, cnt0}, 32'd6);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("clr_prio0", {24'd0, cnt0}, 32'd0);
    chk("clr_prio1", {30'd0, cnt1}, 32'd0);

    // reset at bit 7 abandons the frame
    mode = 2'b01; err_addr = {4'd7, 4'd1};
    for (int b = 0; b < 7; b++) step(1'b1, b == 0, 1'b0, 1'b0);
    rst = 1'b1; valid = 1'b1; datain = 1'b0;
    #1;
    chk("rst_cnt", {24'd0, cnt0}, 32'd0);
    chk("rst_dout", {31'd0, dout0}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pat = 16'd0;
    for (int b = 0; b < 10; b++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      pat[b] = last0;
    end
    chk("post_rst_noflip", {16'd0, pat}, 32'd0);
    chk("post_rst_cnt", {24'd0, cnt0}, 32'd0);
    frame16("post_rst_frame", 16'h0082);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      enable      = ($urandom_range(0, 7) != 0);
      valid       = ($urandom_range(0, 3) != 0);
      frame_start = ($urandom_range(0, 19) == 0);
      datain      = 1'($urandom);
      clr_count   = ($urandom_range(0, 31) == 0);
      mode        = 2'($urandom);
      err_addr    = 8'($urandom);
      burst_len   = 4'($urandom);
      threshold   = 16'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0; valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
